vend_ctrl: RTL and testbench
============================

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 The module SHALL expose parameter CW, 8, credit/price/change width in half-units.
REQ-002 The module SHALL expose parameter NP, 4, number of products (>=2).
REQ-003 The module SHALL expose parameter SW, 4, per-product stock counter width; stock max SMAX = 2^SW-1.
REQ-004 The module SHALL expose parameter PRICES, NP*CW packed, price of product i at bits [i*CW +: CW]; default 3 for every product.
REQ-005 The module SHALL expose parameter CMAX, 2^CW-1, credit ceiling.
REQ-006 Port clk  in  1  clock; all state updates on rising edge.
REQ-007 Port reset  in  1  asynchronous, active-high reset.
REQ-008 Port coin  in  2  0 none, 1 one half-unit, 2 two half-units (one unit), 3 cancel.
REQ-009 Port sel_valid  in  1  purchase request this cycle.
REQ-010 Port sel  in  clog2(NP)  requested product index.
REQ-011 Port restock  in  1  refill request; restock_id  in  clog2(NP)  product to refill.
REQ-012 Port vend  out  1  one-cycle dispense pulse; vend_id  out  clog2(NP)  dispensed product.
REQ-013 Port change  out  CW  refund/change amount, valid when change_valid=1; change_valid  out  1.
REQ-014 Port nak  out  1  one-cycle pulse: request refused (credit short, stock empty, or sel>=NP).
REQ-015 Port coin_rej  out  1  one-cycle pulse: coin returned, ceiling exceeded.
REQ-016 Port credit  out  CW  current credit; empty_mask  out  NP  bit i=1 when stock[i]==0.

Function
REQ-017 FSM SHALL have states IDLE (credit==0) and HOLD (credit>0); IDLE->HOLD on an accepted coin, HOLD->IDLE on vend or cancel.
REQ-018 All outputs SHALL be registered; vend, nak, coin_rej, change_valid SHALL be single-cycle pulses, deasserted the cycle after.
REQ-019 Coin value v (1 or 2) SHALL be accepted when credit+v<=CMAX: credit_eff=credit+v; otherwise coin_rej=1 and credit_eff=credit.
REQ-020 Credit arithmetic SHALL be CW+1 bits internally; no wrap-around is permitted.
REQ-021 With sel_valid=1 and coin!=3, the purchase SHALL be evaluated against credit_eff (same-cycle coin counts).
REQ-022 Purchase SHALL succeed when sel<NP, stock[sel]>0 and credit_eff>=PRICES[sel]: next cycle vend=1, vend_id=sel, change=credit_eff-PRICES[sel], change_valid=1 (even when change is 0), credit=0, stock[sel] decremented.
REQ-023 A failed purchase SHALL pulse nak, leave credit=credit_eff and stock unchanged, and leave vend=0 and change_valid=0.
REQ-024 Cancel (coin==3) SHALL override sel_valid: change=credit, change_valid=1, credit=0, next state IDLE; cancel with credit 0 SHALL still pulse change_valid with change=0.
REQ-025 Restock SHALL set stock[restock_id] to SMAX; restock_id>=NP SHALL be ignored.
REQ-026 Restock and vend of the same product in the same cycle SHALL resolve to stock=SMAX (restock wins).
REQ-027 empty_mask and credit SHALL reflect post-update register values.

Reset
REQ-028 While reset=1: state IDLE, credit=0, vend=0, vend_id=0, change=0, change_valid=0, nak=0, coin_rej=0, all stocks=SMAX, empty_mask=0.
REQ-029 Reset asserted mid-transaction SHALL discard held credit without a change pulse.
REQ-030 After reset release, the first rising edge SHALL process inputs normally.

Verification
REQ-031 Default params: coin=1,1,2 then sel_valid sel=1 with coin=0 -> vend=1, vend_id=1, change=1, credit=0.
REQ-032 coin=2 with sel_valid sel=0 in the same cycle, credit=1 beforehand -> vend=1, change=0, change_valid=1.
REQ-033 credit=2, sel_valid sel=2 -> nak=1, credit stays 2; then coin=3 -> change=2, change_valid=1, credit=0.
REQ-034 15 vends of product 3 -> empty_mask=4'b1000; 16th request -> nak=1, credit retained; restock id 3 -> empty_mask=0.
REQ-035 CW=3 (CMAX=7), credit=6, coin=2 -> coin_rej=1, credit=6; coin=1 -> credit=7.
REQ-036 Reset asserted with credit=3 -> credit=0, change_valid stays 0, stocks=SMAX.

Source files
------------

// File: rtl/vend_ctrl.sv
// -----------------------------------------------------------------------------
// vend_ctrl -- vending machine controller.
//
// Accumulates coin credit in half-units, evaluates purchase requests against
// per-product prices and stock counters, dispenses with change, and refunds
// held credit on cancel. Every output is registered.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   coin         in   0 none, 1 half-unit, 2 one unit, 3 cancel
//   sel_valid    in   purchase request this cycle
//   sel          in   requested product index
//   restock      in   refill request
//   restock_id   in   product to refill (ids >= NP are ignored)
//   vend         out  one-cycle dispense pulse
//   vend_id      out  dispensed product (0 when not vending)
//   change       out  refund/change amount, valid with change_valid
//   change_valid out  one-cycle pulse qualifying change
//   nak          out  one-cycle pulse: purchase refused
//   coin_rej     out  one-cycle pulse: coin returned, credit ceiling reached
//   credit       out  current credit
//   empty_mask   out  bit i set when product i has no stock
//   state_dbg    out  FSM state (0 IDLE, 1 HOLD) for observation
//
// Handshake: inputs are sampled on every rising edge; there is no
// back-pressure. Each pulse output is high for exactly the one cycle
// following the edge that produced it.
// -----------------------------------------------------------------------------
module vend_ctrl #(
    parameter int                CW     = 8,
    parameter int                NP     = 4,
    parameter int                SW     = 4,
    parameter logic [NP*CW-1:0]  PRICES = {NP{CW'(3)}},
    parameter int                CMAX   = (1 << CW) - 1,
    localparam int               SELW   = $clog2(NP)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      coin,
    input  logic            sel_valid,
    input  logic [SELW-1:0] sel,
    input  logic            restock,
    input  logic [SELW-1:0] restock_id,
    output logic            vend,
    output logic [SELW-1:0] vend_id,
    output logic [CW-1:0]   change,
    output logic            change_valid,
    output logic            nak,
    output logic            coin_rej,
    output logic [CW-1:0]   credit,
    output logic [NP-1:0]   empty_mask,
    output logic            state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [SW-1:0] SMAX   = {SW{1'b1}};
    localparam logic [CW:0]   CMAX_W = (CW+1)'(CMAX);

    // Registered state and outputs
    state_t          state_q, state_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic [SW-1:0]   stock_q [NP];
    logic [SW-1:0]   stock_d [NP];
    logic            vend_q, vend_d;
    logic [SELW-1:0] vend_id_q, vend_id_d;
    logic [CW-1:0]   change_q, change_d;
    logic            change_valid_q, change_valid_d;
    logic            nak_q, nak_d;
    logic            coin_rej_q, coin_rej_d;
    logic [NP-1:0]   empty_q, empty_d;

    // Combinational helpers
    logic [CW:0]     coin_val;
    logic [CW:0]     credit_sum;
    logic [CW:0]     credit_eff;
    logic            coin_acc;
    logic            cancel;
    logic [SW-1:0]   stock_sel;
    logic [CW-1:0]   price_sel;
    logic            buy_ok;
    logic [CW:0]     change_amt;

    always_comb begin
        coin_val = '0;
        case (coin)
            2'd1:    coin_val = (CW+1)'(1);
            2'd2:    coin_val = (CW+1)'(2);
            default: coin_val = '0;
        endcase
        cancel = (coin == 2'd3);

        // One extra bit keeps the ceiling test free of wrap-around.
        credit_sum = {1'b0, credit_q} + coin_val;
        coin_acc   = (coin_val != '0) && (credit_sum <= CMAX_W);
        credit_eff = coin_acc ? credit_sum : {1'b0, credit_q};

        // An out-of-range sel matches no product, so stock_sel stays 0 and
        // the request is refused like an empty slot.
        stock_sel = '0;
        price_sel = '0;
        for (int i = 0; i < NP; i++) begin
            if (sel == SELW'(i)) begin
                stock_sel = stock_q[i];
                price_sel = PRICES[i*CW +: CW];
            end
        end

        buy_ok     = sel_valid && !cancel && (stock_sel != '0) &&
                     (credit_eff >= {1'b0, price_sel});
        change_amt = credit_eff - {1'b0, price_sel};

        // Defaults: pulses low, credit carries the effective value.
        vend_d         = 1'b0;
        vend_id_d      = '0;
        change_d       = '0;
        change_valid_d = 1'b0;
        nak_d          = sel_valid && !cancel && !buy_ok;
        coin_rej_d     = (coin_val != '0) && !coin_acc;
        credit_d       = credit_eff[CW-1:0];
        for (int i = 0; i < NP; i++) begin
            stock_d[i] = stock_q[i];
        end

        if (cancel) begin
            // Cancel refunds the credit held before this cycle.
            change_d       = credit_q;
            change_valid_d = 1'b1;
            credit_d       = '0;
        end else if (buy_ok) begin
            vend_d         = 1'b1;
            vend_id_d      = sel;
            change_d       = change_amt[CW-1:0];
            change_valid_d = 1'b1;
            credit_d       = '0;
            for (int i = 0; i < NP; i++) begin
                if (sel == SELW'(i)) begin
                    stock_d[i] = stock_q[i] - SW'(1);
                end
            end
        end

        // Restock is applied last so it wins over a same-cycle vend.
        if (restock) begin
            for (int i = 0; i < NP; i++) begin
                if (restock_id == SELW'(i)) begin
                    stock_d[i] = SMAX;
                end
            end
        end

        for (int i = 0; i < NP; i++) begin
            empty_d[i] = (stock_d[i] == '0);
        end

        state_d = (credit_d != '0) ? HOLD : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            vend_q         <= 1'b0;
            vend_id_q      <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            nak_q          <= 1'b0;
            coin_rej_q     <= 1'b0;
            empty_q        <= '0;
            for (int i = 0; i < NP; i++) begin
                stock_q[i] <= SMAX;
            end
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_q         <= vend_d;
            vend_id_q      <= vend_id_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            nak_q          <= nak_d;
            coin_rej_q     <= coin_rej_d;
            empty_q        <= empty_d;
            for (int i = 0; i < NP; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign vend         = vend_q;
    assign vend_id      = vend_id_q;
    assign change       = change_q;
    assign change_valid = change_valid_q;
    assign nak          = nak_q;
    assign coin_rej     = coin_rej_q;
    assign credit       = credit_q;
    assign empty_mask   = empty_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_ctrl -- self-checking bench for vend_ctrl.
// dut1: default parameters (CW=8, NP=4, SW=4, all prices 3).
// dut2: CW=3 (CMAX=7), NP=3, SW=2 (SMAX=3), all prices 3.
// Outputs are packed into one 26-bit word:
//   {vend, vend_id[1:0], change[7:0], change_valid, nak, coin_rej,
//    credit[7:0], empty_mask[3:0]}
// -----------------------------------------------------------------------------
module tb_vend_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2;

  // ---------------- dut1 ----------------
  logic [1:0] coin1;
  logic       sv1, rs1;
  logic [1:0] sel1, rid1;
  logic       vend1, cv1, nak1, rej1, st1;
  logic [1:0] vid1;
  logic [7:0] chg1, cred1;
  logic [3:0] mask1;

  vend_ctrl u_dut1 (
    .clk(clk), .reset(rst1), .coin(coin1), .sel_valid(sv1), .sel(sel1),
    .restock(rs1), .restock_id(rid1), .vend(vend1), .vend_id(vid1),
    .change(chg1), .change_valid(cv1), .nak(nak1), .coin_rej(rej1),
    .credit(cred1), .empty_mask(mask1), .state_dbg(st1)
  );

  // ---------------- dut2 ----------------
  logic [1:0] coin2;
  logic       sv2, rs2;
  logic [1:0] sel2, rid2;
  logic       vend2, cv2, nak2, rej2, st2;
  logic [1:0] vid2;
  logic [2:0] chg2, cred2, mask2;

  vend_ctrl #(.CW(3), .NP(3), .SW(2)) u_dut2 (
    .clk(clk), .reset(rst2), .coin(coin2), .sel_valid(sv2), .sel(sel2),
    .restock(rs2), .restock_id(rid2), .vend(vend2), .vend_id(vid2),
    .change(chg2), .change_valid(cv2), .nak(nak2), .coin_rej(rej2),
    .credit(cred2), .empty_mask(mask2), .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [25:0] exp_q[$];

  function automatic logic [25:0] mk(input logic v, input logic [1:0] id,
                                     input logic [7:0] chg, input logic cv,
                                     input logic nk, input logic rj,
                                     input logic [7:0] cr, input logic [3:0] m);
    return {v, id, chg, cv, nk, rj, cr, m};
  endfunction

  function automatic logic [25:0] got1();
    return {vend1, vid1, chg1, cv1, nak1, rej1, cred1, mask1};
  endfunction

  function automatic logic [25:0] got2();
    return {vend2, vid2, 5'b0, chg2, cv2, nak2, rej2, 5'b0, cred2, 1'b0, mask2};
  endfunction

  task automatic check(input string name, input logic [25:0] got);
    logic [25:0] e;
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got v=%b id=%0d chg=%0d cv=%b nak=%b rej=%b cr=%0d m=%b, exp v=%b id=%0d chg=%0d cv=%b nak=%b rej=%b cr=%0d m=%b",
               name, got[25], got[24:23], got[22:15], got[14], got[13], got[12], got[11:4], got[3:0],
               e[25], e[24:23], e[22:15], e[14], e[13], e[12], e[11:4], e[3:0]);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step1(input logic [1:0] c, input logic s, input logic [1:0] sl,
                       input logic r, input logic [1:0] ri);
    @(negedge clk);
    coin1 = c; sv1 = s; sel1 = sl; rs1 = r; rid1 = ri;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic [1:0] c, input logic s, input logic [1:0] sl,
                       input logic r, input logic [1:0] ri);
    @(negedge clk);
    coin2 = c; sv2 = s; sel2 = sl; rs2 = r; rid2 = ri;
    @(posedge clk);
    #1;
  endtask

  // Model of product 3 stock on dut1, used for the drain sequences.
  int stock3 = 15;

  // Pay 2 + 1 (with the 1 arriving in the request cycle) and buy product 3.
  task automatic buy3_n(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      step1(2'd2, 1'b0, 2'd0, 1'b0, 2'd0);
      stock3--;
      exp_q.push_back(mk(1, 2'd3, 8'd0, 1, 0, 0, 8'd0, (stock3 == 0) ? 4'b1000 : 4'b0000));
      step1(2'd1, 1'b1, 2'd3, 1'b0, 2'd0);
      check(name, got1());
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  coin;
    logic        sv;
    logic [1:0]  sel;
    logic        rs;
    logic [1:0]  rid;
    logic [25:0] exp;
    string       name;
  } vec_t;

  vec_t vt[15];

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    coin1 = 0; sv1 = 0; sel1 = 0; rs1 = 0; rid1 = 0;
    coin2 = 0; sv2 = 0; sel2 = 0; rs2 = 0; rid2 = 0;

    vt[0]  = '{2'd1, 0, 2'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 8'd1, 0), "coin_half"};
    vt[1]  = '{2'd1, 0, 2'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 8'd2, 0), "coin_half2"};
    vt[2]  = '{2'd2, 0, 2'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 8'd4, 0), "coin_unit"};
    vt[3]  = '{2'd0, 1, 2'd1, 0, 2'd0, mk(1, 1, 8'd1, 1, 0, 0, 8'd0, 0), "buy_p1_change1"};
    vt[4]  = '{2'd1, 0, 2'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 8'd1, 0), "coin_after_vend"};
    vt[5]  = '{2'd2, 1, 2'd0, 0, 2'd0, mk(1, 0, 8'd0, 1, 0, 0, 8'd0, 0), "same_cycle_coin_buy"};
    vt[6]  = '{2'd2, 0, 2'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 8'd2, 0), "coin_unit2"};
    vt[7]  = '{2'd0, 1, 2'd2, 0, 2'd0, mk(0, 0, 0, 0, 1, 0, 8'd2, 0), "nak_short"};
    vt[8]  = '{2'd3, 0, 2'd0, 0, 2'd0, mk(0, 0, 8'd2, 1, 0, 0, 8'd0, 0), "cancel_refund2"};
    vt[9]  = '{2'd3, 0, 2'd0, 0, 2'd0, mk(0, 0, 8'd0, 1, 0, 0, 8'd0, 0), "cancel_zero"};
    vt[10] = '{2'd2, 0, 2'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 8'd2, 0), "coin_unit3"};
    vt[11] = '{2'd3, 1, 2'd0, 0, 2'd0, mk(0, 0, 8'd2, 1, 0, 0, 8'd0, 0), "cancel_over_sel"};
    vt[12] = '{2'd0, 1, 2'd0, 0, 2'd0, mk(0, 0, 0, 0, 1, 0, 8'd0, 0), "nak_no_credit"};
    vt[13] = '{2'd0, 0, 2'd0, 1, 2'd1, mk(0, 0, 0, 0, 0, 0, 8'd0, 0), "restock_p1"};
    vt[14] = '{2'd0, 0, 2'd0, 0, 2'd0, mk(0, 0, 0, 0, 0, 0, 8'd0, 0), "quiet"};

    // ---- reset state ----
    #12;
    exp_q.push_back(26'd0); check("reset1", got1());
    exp_q.push_back(26'd0); check("reset2", got2());
    @(negedge clk);
    rst1 = 1'b0; rst2 = 1'b0;

    // ---- table ----
    for (int i = 0; i < 15; i++) begin
      step1(vt[i].coin, vt[i].sv, vt[i].sel, vt[i].rs, vt[i].rid);
      exp_q.push_back(vt[i].exp);
      check(vt[i].name, got1());
    end

    // ---- drain product 3, then refuse, restock, restock+vend ----
    buy3_n(15, "drain_p3");
    step1(2'd2, 0, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'd2, 4'b1000)); check("coin_empty", got1());
    step1(2'd2, 0, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'd4, 4'b1000)); check("coin_empty2", got1());
    step1(2'd0, 1, 2'd3, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 8'd4, 4'b1000)); check("nak_empty", got1());
    step1(2'd0, 0, 2'd0, 1, 2'd3);
    stock3 = 15;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'd4, 4'b0000)); check("restock_p3", got1());
    step1(2'd0, 1, 2'd3, 1, 2'd3);
    exp_q.push_back(mk(1, 2'd3, 8'd1, 1, 0, 0, 8'd0, 4'b0000)); check("restock_wins", got1());
    // Stock must be SMAX again: 14 vends leave it non-empty, the 15th empties it.
    buy3_n(15, "drain_after_restock");

    // ---- asynchronous reset mid-transaction ----
    step1(2'd2, 0, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'd2, 4'b1000)); check("pre_reset_a", got1());
    step1(2'd1, 0, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'd3, 4'b1000)); check("pre_reset_b", got1());
    coin1 = 2'd0;
    #2 rst1 = 1'b1;
    #1;
    exp_q.push_back(26'd0); check("async_reset", got1());
    @(posedge clk); #1;
    exp_q.push_back(26'd0); check("reset_held", got1());
    @(negedge clk);
    rst1 = 1'b0;
    step1(2'd1, 0, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'd1, 0)); check("first_edge_after_reset", got1());
    step1(2'd3, 0, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 8'd1, 1, 0, 0, 8'd0, 0)); check("cancel_after_reset", got1());

    // ---- dut2: credit ceiling, sel >= NP, restock_id >= NP ----
    step2(2'd2, 0, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'd2, 0)); check("d2_coin2", got2());
    step2(2'd2, 0, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'd4, 0)); check("d2_coin4", got2());
    step2(2'd2, 0, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'd6, 0)); check("d2_coin6", got2());
    step2(2'd2, 0, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 8'd6, 0)); check("d2_coin_rej", got2());
    step2(2'd1, 0, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'd7, 0)); check("d2_credit_max", got2());
    step2(2'd1, 0, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 8'd7, 0)); check("d2_rej_at_max", got2());
    step2(2'd0, 1, 2'd3, 0, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 8'd7, 0)); check("d2_sel_oor", got2());
    step2(2'd0, 1, 2'd0, 0, 2'd0);
    exp_q.push_back(mk(1, 0, 8'd4, 1, 0, 0, 8'd0, 0)); check("d2_buy_change4", got2());
    for (int k = 0; k < 2; k++) begin
      step2(2'd2, 0, 2'd0, 0, 2'd0);
      step2(2'd1, 1, 2'd0, 0, 2'd0);
      exp_q.push_back(mk(1, 0, 8'd0, 1, 0, 0, 8'd0, (k == 1) ? 4'b0001 : 4'b0000));
      check("d2_drain_p0", got2());
    end
    step2(2'd0, 0, 2'd0, 1, 2'd3);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'd0, 4'b0001)); check("d2_restock_oor", got2());
    step2(2'd0, 0, 2'd0, 1, 2'd0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 8'd0, 4'b0000)); check("d2_restock_p0", got2());

    // ---- report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, required finished");
    $fatal(1);
  end

endmodule
